// File: rtl/ksa_sub_pipe.sv
// ksa_sub_pipe: three-stage pipelined Kogge-Stone subtractor, o_d = i_a - i_b - i_bin.
// The subtraction is computed as a + ~b + ~bin on a parallel-prefix carry tree.
// Stage 1 registers bit propagate/generate with the carry-in folded into bit 0.
// Stage 2 registers the first half of the prefix levels.
// Stage 3 finishes the tree and registers the difference, borrow and overflow.
// Each stage loads when it is empty or when the stage after it loads, so the
// pipeline collapses bubbles; there is no skid buffer.
// Optional feature macro: KSA_SUB_SAT_EN (saturate o_d on signed overflow).
module ksa_sub_pipe #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_d,
    output logic         o_borrow,
    output logic         o_ovf
);

    // Prefix levels; the first half run between S1 and S2, the rest between S2 and S3
    localparam int L = $clog2(W);
    localparam int H = (L + 1) / 2;

    // Runs Kogge-Stone levels lvl_lo..lvl_hi (span 2^(lvl-1)); returns {P, G}
    function automatic logic [2*W-1:0] ks_levels(
        input logic [W-1:0] p_in,
        input logic [W-1:0] g_in,
        input int           lvl_lo,
        input int           lvl_hi
    );
        logic [W-1:0] p;
        logic [W-1:0] g;
        logic [W-1:0] pn;
        logic [W-1:0] gn;
        p  = p_in;
        g  = g_in;
        pn = p_in;
        gn = g_in;
        for (int lvl = lvl_lo; lvl <= lvl_hi; lvl++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << (lvl - 1))) begin
                    gn[i] = g[i] | (p[i] & g[i - (1 << (lvl - 1))]);
                    pn[i] = p[i] & p[i - (1 << (lvl - 1))];
                end else begin
                    gn[i] = g[i];
                    pn[i] = p[i];
                end
            end
            p = pn;
            g = gn;
        end
        return {p, g};
    endfunction

    // Pipeline occupancy
    logic r_v1;
    logic r_v2;
    logic r_v3;

    // S1 data: bit propagate (also the half-sum), generate with cin folded in
    logic [W-1:0] r_p1;
    logic [W-1:0] r_g1;
    logic         r_cin1;
    logic         r_amsb1;
    logic         r_bmsb1;

    // S2 data: group P/G after the first half of the tree, plus the half-sum
    logic [W-1:0] r_hp2;
    logic [W-1:0] r_p2;
    logic [W-1:0] r_g2;
    logic         r_cin2;
    logic         r_amsb2;
    logic         r_bmsb2;

    // Output registers
    logic [W-1:0] r_d3;
    logic         r_borrow3;
    logic         r_ovf3;

    // Load enables and combinational datapath nets
    logic         w_ld1;
    logic         w_ld2;
    logic         w_ld3;
    logic [W-1:0] w_p0;
    logic [W-1:0] w_g0;
    logic         w_cin0;
    logic [2*W-1:0] w_pg_half;
    logic [2*W-1:0] w_pg_full;
    logic [W-1:0] w_gfull;
    logic [W-1:0] w_d_raw;
    logic         w_ovf;
    logic [W-1:0] w_d_out;

    // Handshake: each stage loads when empty or when the next stage drains it
    always_comb begin
        w_ld3   = (!r_v3) || i_ready;
        w_ld2   = (!r_v2) || w_ld3;
        w_ld1   = (!r_v1) || w_ld2;
        o_ready = w_ld1;
    end

    // Level 0: bitwise p/g of a and ~b, carry-in folded into bit 0
    always_comb begin
        w_cin0 = ~i_bin;
        w_p0   = i_a ^ ~i_b;
        w_g0   = i_a & ~i_b;
        w_g0[0] = w_g0[0] | (w_p0[0] & w_cin0);
    end

    // First half of the prefix tree, feeding S2
    always_comb begin
        w_pg_half = ks_levels(r_p1, r_g1, 1, H);
    end

    // Remaining prefix levels, sum, overflow and optional saturation, feeding S3
    always_comb begin
        w_pg_full = ks_levels(r_p2, r_g2, H + 1, L);
        w_gfull   = w_pg_full[W-1:0];
        w_d_raw   = r_hp2 ^ {w_gfull[W-2:0], r_cin2};
        w_ovf     = (r_amsb2 != r_bmsb2) && (w_d_raw[W-1] != r_amsb2);
`ifdef KSA_SUB_SAT_EN
        if (w_ovf) begin
            w_d_out = r_amsb2 ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            w_d_out = w_d_raw;
        end
`else
        w_d_out = w_d_raw;
`endif
    end

    // Valid bits advance whenever their stage loads
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_ld1) r_v1 <= i_valid;
            else       r_v1 <= r_v1;
            if (w_ld2) r_v2 <= r_v1;
            else       r_v2 <= r_v2;
            if (w_ld3) r_v3 <= r_v2;
            else       r_v3 <= r_v3;
        end
    end

    // S1 data captures only an accepted beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p1    <= {W{1'b0}};
            r_g1    <= {W{1'b0}};
            r_cin1  <= 1'b0;
            r_amsb1 <= 1'b0;
            r_bmsb1 <= 1'b0;
        end else if (w_ld1 && i_valid) begin
            r_p1    <= w_p0;
            r_g1    <= w_g0;
            r_cin1  <= w_cin0;
            r_amsb1 <= i_a[W-1];
            r_bmsb1 <= i_b[W-1];
        end else begin
            r_p1    <= r_p1;
            r_g1    <= r_g1;
            r_cin1  <= r_cin1;
            r_amsb1 <= r_amsb1;
            r_bmsb1 <= r_bmsb1;
        end
    end

    // S2 data captures a valid S1 beat moving forward
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hp2   <= {W{1'b0}};
            r_p2    <= {W{1'b0}};
            r_g2    <= {W{1'b0}};
            r_cin2  <= 1'b0;
            r_amsb2 <= 1'b0;
            r_bmsb2 <= 1'b0;
        end else if (w_ld2 && r_v1) begin
            r_hp2   <= r_p1;
            r_p2    <= w_pg_half[2*W-1:W];
            r_g2    <= w_pg_half[W-1:0];
            r_cin2  <= r_cin1;
            r_amsb2 <= r_amsb1;
            r_bmsb2 <= r_bmsb1;
        end else begin
            r_hp2   <= r_hp2;
            r_p2    <= r_p2;
            r_g2    <= r_g2;
            r_cin2  <= r_cin2;
            r_amsb2 <= r_amsb2;
            r_bmsb2 <= r_bmsb2;
        end
    end

    // S3 output registers hold steady while downstream stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d3      <= {W{1'b0}};
            r_borrow3 <= 1'b0;
            r_ovf3    <= 1'b0;
        end else if (w_ld3 && r_v2) begin
            r_d3      <= w_d_out;
            r_borrow3 <= ~w_gfull[W-1];
            r_ovf3    <= w_ovf;
        end else begin
            r_d3      <= r_d3;
            r_borrow3 <= r_borrow3;
            r_ovf3    <= r_ovf3;
        end
    end

    assign o_valid  = r_v3;
    assign o_d      = r_d3;
    assign o_borrow = r_borrow3;
    assign o_ovf    = r_ovf3;

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Directed and randomised bench for ksa_sub_pipe (W=32). Honours KSA_SUB_SAT_EN.
module tb_ksa_sub_pipe;

    localparam int W = 32;
    localparam logic [W-1:0] SMAX = 32'h7FFF_FFFF;
    localparam logic [W-1:0] SMIN = 32'h8000_0000;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_bin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_d;
    logic         o_borrow;
    logic         o_ovf;

    ksa_sub_pipe #(.W(W)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_bin    (i_bin),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_d      (o_d),
        .o_borrow (o_borrow),
        .o_ovf    (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        int           c;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic lat_chk  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: a - b - bin computed at W+1 bits
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        logic [W:0]   diff;
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        d    = diff[W-1:0];
        br   = diff[W];
        ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
`ifdef KSA_SUB_SAT_EN
        if (ov) d = a[W-1] ? SMIN : SMAX;
`endif
        return {br, ov, d};
    endfunction

    // One clock cycle: drive, observe emit/accept at posedge+2, advance
    task automatic run_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bin, input logic rdy, input logic [W-1:0] ed,
                             input logic eb, input logic eo, output logic acc);
        exp_t e;
        i_valid = v;
        i_a     = a;
        i_b     = b;
        i_bin   = bin;
        i_ready = rdy;
        #1;
        acc = v && o_ready;
        if (o_valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_beat observed=%0h expected=none", o_d);
            end else begin
                e = exp_q.pop_front();
                chk("d", {32'h0, o_d}, {32'h0, e.d});
                chk("borrow", {63'h0, o_borrow}, {63'h0, e.br});
                chk("ovf", {63'h0, o_ovf}, {63'h0, e.ov});
                if (lat_chk) chk("latency", 64'(cyc - e.c), 64'd3);
            end
        end
        if (acc) begin
            e.d = ed; e.br = eb; e.ov = eo; e.c = cyc;
            exp_q.push_back(e);
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        logic acc;
        for (int n = 0; n < budget && exp_q.size() != 0; n++)
            run_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    logic [W-1:0] va[8];
    logic [W-1:0] vb[8];
    logic         vbin[8];
    logic [W-1:0] vd[8];
    logic         vbr[8];
    logic         vov[8];

    initial begin
        logic         acc;
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic         rv;
        int           k;
        int           nacc;

        // Test 1: reset while i_valid is high
        i_rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        i_a = 32'd5; i_b = 32'd3; i_bin = 1'b0;
        #2;
        @(posedge i_clk); #1;
        chk("rst_valid", {63'h0, o_valid}, 64'd0);
        chk("rst_ready", {63'h0, o_ready}, 64'd1);
        chk("rst_d", {32'h0, o_d}, 64'd0);
        chk("rst_borrow", {63'h0, o_borrow}, 64'd0);
        chk("rst_ovf", {63'h0, o_ovf}, 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        lat_chk = 1'b1;
        run_cycle(1'b1, 32'd5, 32'd3, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, acc);
        chk("t1_accept", {63'h0, acc}, 64'd1);
        drain(10);

        // Test 2: borrow cases
        run_cycle(1'b1, 32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
        drain(10);
        run_cycle(1'b1, SMAX, SMAX, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
        drain(10);

        // Test 3: signed overflow
`ifdef KSA_SUB_SAT_EN
        run_cycle(1'b1, SMIN, 32'h1, 1'b0, 1'b1, SMIN, 1'b0, 1'b1, acc);
`else
        run_cycle(1'b1, SMIN, 32'h1, 1'b0, 1'b1, SMAX, 1'b0, 1'b1, acc);
`endif
        drain(10);

        // Test 4: eight back-to-back beats, hand-computed results
        va[0] = 32'd10;        vb[0] = 32'd3;         vbin[0] = 1'b0; vd[0] = 32'd7;         vbr[0] = 1'b0; vov[0] = 1'b0;
        va[1] = 32'd3;         vb[1] = 32'd10;        vbin[1] = 1'b0; vd[1] = 32'hFFFF_FFF9; vbr[1] = 1'b1; vov[1] = 1'b0;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; vbin[2] = 1'b1; vd[2] = 32'hFFFF_FFFF; vbr[2] = 1'b1; vov[2] = 1'b0;
        va[3] = SMIN;          vb[3] = SMIN;          vbin[3] = 1'b0; vd[3] = 32'h0;         vbr[3] = 1'b0; vov[3] = 1'b0;
        va[5] = 32'h1234_5678; vb[5] = 32'h0234_5678; vbin[5] = 1'b1; vd[5] = 32'h0FFF_FFFF; vbr[5] = 1'b0; vov[5] = 1'b0;
        va[6] = 32'h0;         vb[6] = 32'h0;         vbin[6] = 1'b1; vd[6] = 32'hFFFF_FFFF; vbr[6] = 1'b1; vov[6] = 1'b0;
        va[4] = SMAX;          vb[4] = 32'hFFFF_FFFF; vbin[4] = 1'b0; vbr[4] = 1'b1; vov[4] = 1'b1;
        va[7] = 32'hAAAA_AAAA; vb[7] = 32'h5555_5555; vbin[7] = 1'b0; vbr[7] = 1'b0; vov[7] = 1'b1;
`ifdef KSA_SUB_SAT_EN
        vd[4] = SMAX;
        vd[7] = SMIN;
`else
        vd[4] = SMIN;
        vd[7] = 32'h5555_5555;
`endif
        for (int i = 0; i < 8; i++)
            run_cycle(1'b1, va[i], vb[i], vbin[i], 1'b1, vd[i], vbr[i], vov[i], acc);
        drain(10);

        // Test 5: downstream stall of 5 cycles while the source streams
        lat_chk = 1'b0;
        k = 0;
        nacc = 0;
        for (int j = 0; j < 40 && k < 8; j++) begin
            run_cycle(1'b1, va[k], vb[k], vbin[k], (j >= 5), vd[k], vbr[k], vov[k], acc);
            if (acc) begin
                k++;
                nacc++;
            end
            if (j == 2) chk("ready_low_full", {63'h0, o_ready}, 64'd0);
            if (j == 4) chk("stall_accepts", 64'(nacc), 64'd3);
        end
        chk("t5_all_sent", 64'(k), 64'd8);
        drain(20);

        // Test 6: reset with three beats in flight, then random traffic
        for (int i = 0; i < 3; i++)
            run_cycle(1'b1, va[i], vb[i], vbin[i], 1'b0, vd[i], vbr[i], vov[i], acc);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'h0, o_valid}, 64'd0);
        chk("midrst_ready", {63'h0, o_ready}, 64'd1);
        exp_q.delete();
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        cyc++;
        k = 0;
        rv = 1'b0;
        ra = 32'h0; rb = 32'h0; rbin = 1'b0;
        for (int j = 0; j < 60000 && k < 10000; j++) begin
            if (!rv) begin
                rv   = ($urandom_range(3, 0) != 0);
                ra   = $urandom;
                rb   = ($urandom_range(7, 0) == 0) ? ra : $urandom;
                rbin = $urandom_range(1, 0);
            end
            m = model(ra, rb, rbin);
            run_cycle(rv, ra, rb, rbin, ($urandom_range(4, 0) != 0), m[W-1:0], m[W+1], m[W], acc);
            if (acc) begin
                k++;
                rv = 1'b0;
            end
        end
        chk("rand_beats", 64'(k), 64'd10000);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
